// File: rtl/core_pkg.sv
// Shared definitions for the core run-control slice.
//   run_state_t : sequencer states
//   ERR_*       : host-visible error codes on err[1:0]
//   D, W        : instruction-memory address width (program-counter width)
//                 and machine-word width, shared with the PC and instr ROM
package core_pkg;

  localparam int D = 12;
  localparam int W = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    DONE,
    ERR
  } run_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_TMO  = 2'd1;
  localparam logic [1:0] ERR_OVF  = 2'd2;

endpackage

// File: rtl/core_run_ctrl_if.sv
// Host / instruction-memory / core bundle of the run controller.
//   slave  : the controller (core_run_ctrl)
//   master : the host-and-core environment driving it
// Host side : req, load_valid, load_word, load_last -> ; <- load_ready, busy, ack, err, cycle_cnt
// Memory    : <- imem_we, imem_addr, imem_wdata
// Core      : <- core_reset ; core_done ->
interface core_run_ctrl_if #(
  parameter int D  = core_pkg::D,
  parameter int W  = core_pkg::W,
  parameter int CW = 16
) ();

  logic          req;
  logic          load_valid;
  logic [W-1:0]  load_word;
  logic          load_last;
  logic          load_ready;
  logic          imem_we;
  logic [D-1:0]  imem_addr;
  logic [W-1:0]  imem_wdata;
  logic          core_reset;
  logic          core_done;
  logic          busy;
  logic          ack;
  logic [1:0]    err;
  logic [CW-1:0] cycle_cnt;

  modport slave (
    input  req, load_valid, load_word, load_last, core_done,
    output load_ready, imem_we, imem_addr, imem_wdata, core_reset,
           busy, ack, err, cycle_cnt
  );

  modport master (
    output req, load_valid, load_word, load_last, core_done,
    input  load_ready, imem_we, imem_addr, imem_wdata, core_reset,
           busy, ack, err, cycle_cnt
  );

endinterface

// File: rtl/run_watchdog.sv
// RUN-cycle counter with saturation and timeout flag.
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   clr      : clear count (start of a new run)
//   en       : count this cycle
//   cnt      : cycles counted, saturates at MAX_CYC
//   tmo      : count has reached MAX_CYC
module run_watchdog #(
  parameter int          CW      = 16,
  parameter int unsigned MAX_CYC = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tmo
);

  assign tmo = (cnt == CW'(MAX_CYC));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !tmo) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run sequencer in front of the processor core.
// Streams host words into instruction memory, holds the core in reset for
// RST_CYC cycles, releases it, counts RUN cycles until core_done or the
// watchdog limit, then reports through a req/ack level handshake.
//   clk, reset : clock, synchronous active-high reset
//   bus        : core_run_ctrl_if.slave (host load stream, imem write port,
//                core reset/done, busy/ack/err/cycle_cnt status)
module core_run_ctrl
  // Explicit item imports: the package widths only serve as defaults for
  // the D/W parameters below, which may be overridden per instance.
  import core_pkg::run_state_t, core_pkg::IDLE, core_pkg::LOAD, core_pkg::HOLD,
         core_pkg::RUN, core_pkg::DONE, core_pkg::ERR,
         core_pkg::ERR_NONE, core_pkg::ERR_TMO, core_pkg::ERR_OVF;
#(
  parameter int          D       = core_pkg::D,
  parameter int          W       = core_pkg::W,
  parameter int          RST_CYC = 2,
  parameter int          CW      = 16,
  parameter int unsigned MAX_CYC = 16'hFFFF
) (
  input logic            clk,
  input logic            reset,
  core_run_ctrl_if.slave bus
);

  localparam int HW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  run_state_t    state;
  logic [D-1:0]  ptr;
  logic [HW-1:0] hold_cnt;
  logic          accept;
  logic          enter_hold;
  logic          overflow;
  logic          wd_en;
  logic          tmo;

  assign bus.load_ready = (state == IDLE) || (state == LOAD);
  assign bus.busy       = (state == LOAD) || (state == HOLD) || (state == RUN);
  assign bus.ack        = (state == DONE) || (state == ERR);

  assign accept = bus.load_valid && bus.load_ready;

  // A word tagged last always heads to HOLD, even a one-word program
  // arriving in IDLE; otherwise its last flag would be lost in LOAD.
  assign enter_hold = (accept && bus.load_last) ||
                      ((state == IDLE) && !bus.load_valid && bus.req);

  // Last address filled without load_last: no room left for the program.
  assign overflow = accept && !bus.load_last && (state == LOAD) && (&ptr);

  assign wd_en = (state == RUN) && !bus.core_done;

  run_watchdog #(
    .CW      (CW),
    .MAX_CYC (MAX_CYC)
  ) u_watchdog (
    .clk (clk),
    .rst (reset),
    .clr (enter_hold),
    .en  (wd_en),
    .cnt (bus.cycle_cnt),
    .tmo (tmo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      hold_cnt       <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.core_reset <= 1'b1;
      bus.err        <= ERR_NONE;
    end else begin
      bus.imem_we <= 1'b0;

      // Write port: one-cycle pulse per accepted word; pointer restarts at
      // 0 for a load begun from IDLE and sticks at the top address.
      if (accept) begin
        bus.imem_we    <= 1'b1;
        bus.imem_wdata <= W'(bus.load_word);
        if (state == IDLE) begin
          bus.imem_addr <= '0;
          ptr           <= D'(1);
        end else begin
          bus.imem_addr <= ptr;
          if (!(&ptr)) ptr <= ptr + D'(1);
        end
      end

      if (enter_hold) begin
        state          <= HOLD;
        hold_cnt       <= '0;
        bus.err        <= ERR_NONE;
        bus.core_reset <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (bus.load_valid) state <= LOAD;
          end
          LOAD: begin
            if (overflow) begin
              state   <= ERR;
              bus.err <= ERR_OVF;
            end
          end
          HOLD: begin
            if (hold_cnt == HW'(RST_CYC - 1)) begin
              state          <= RUN;
              bus.core_reset <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          RUN: begin
            // core_done has priority over a simultaneous timeout.
            if (bus.core_done) begin
              state <= DONE;
            end else if (tmo) begin
              state          <= ERR;
              bus.err        <= ERR_TMO;
              bus.core_reset <= 1'b1;
            end
          end
          DONE: begin
            if (!bus.req) begin
              state          <= IDLE;
              bus.core_reset <= 1'b1;
            end
          end
          ERR: begin
            if (!bus.req) state <= IDLE;
          end
          default: begin
            state          <= IDLE;
            bus.core_reset <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
module tb_core_run_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   exp_a[$];
  int   exp_b[$];

  always #5 clk = ~clk;

  core_run_ctrl_if #(.D(3),  .W(9), .CW(16)) a_if ();
  core_run_ctrl_if #(.D(12), .W(9), .CW(16)) b_if ();

  core_run_ctrl #(.D(3), .W(9), .RST_CYC(2), .CW(16), .MAX_CYC(20)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.slave)
  );

  core_run_ctrl #(.D(12), .W(9), .RST_CYC(2), .CW(16), .MAX_CYC(8)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  // Scoreboards: expected writes encoded as addr*512 + data.
  always @(negedge clk) begin
    int act, e;
    if (a_if.imem_we === 1'b1) begin
      act = int'(a_if.imem_addr) * 512 + int'(a_if.imem_wdata);
      total++;
      if (exp_a.size() == 0) begin
        bad++; $display("FAIL imem_a_unexpected got=%0h want=none", act);
      end else begin
        e = exp_a.pop_front();
        if (act !== e) begin bad++; $display("FAIL imem_a_write got=%0h want=%0h", act, e); end
      end
    end
    if (b_if.imem_we === 1'b1) begin
      act = int'(b_if.imem_addr) * 512 + int'(b_if.imem_wdata);
      total++;
      if (exp_b.size() == 0) begin
        bad++; $display("FAIL imem_b_unexpected got=%0h want=none", act);
      end else begin
        e = exp_b.pop_front();
        if (act !== e) begin bad++; $display("FAIL imem_b_write got=%0h want=%0h", act, e); end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_if.req = 0; a_if.load_valid = 0; a_if.load_word = '0; a_if.load_last = 0; a_if.core_done = 0;
    b_if.req = 0; b_if.load_valid = 0; b_if.load_word = '0; b_if.load_last = 0; b_if.core_done = 0;
    reset = 1;
    tick(); tick();
    total++; if (a_if.core_reset !== 1'b1) begin bad++; $display("FAIL rst_core_reset got=%0b want=1", a_if.core_reset); end
    total++; if (a_if.imem_we !== 1'b0) begin bad++; $display("FAIL rst_imem_we got=%0b want=0", a_if.imem_we); end
    total++; if (a_if.imem_addr !== 3'd0) begin bad++; $display("FAIL rst_imem_addr got=%0h want=0", a_if.imem_addr); end
    total++; if (a_if.imem_wdata !== 9'd0) begin bad++; $display("FAIL rst_imem_wdata got=%0h want=0", a_if.imem_wdata); end
    total++; if (a_if.err !== 2'd0) begin bad++; $display("FAIL rst_err got=%0d want=0", a_if.err); end
    total++; if (a_if.cycle_cnt !== 16'd0) begin bad++; $display("FAIL rst_cycle_cnt got=%0d want=0", a_if.cycle_cnt); end
    total++; if (a_if.load_ready !== 1'b1) begin bad++; $display("FAIL rst_load_ready got=%0b want=1", a_if.load_ready); end
    total++; if (a_if.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", a_if.busy); end
    total++; if (a_if.ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%0b want=0", a_if.ack); end
    total++; if (b_if.core_reset !== 1'b1) begin bad++; $display("FAIL rst_b_core_reset got=%0b want=1", b_if.core_reset); end
    reset = 0;
  endtask

  task automatic test_load_run();
    logic [8:0] words [3];
    words[0] = 9'h1C8; words[1] = 9'h005; words[2] = 9'h0FF;
    a_if.req = 1;
    for (int i = 0; i < 3; i++) begin
      a_if.load_valid = 1; a_if.load_word = words[i]; a_if.load_last = (i == 2);
      exp_a.push_back(i * 512 + int'(words[i]));
      tick();
    end
    a_if.load_valid = 0; a_if.load_last = 0;
    total++; if (a_if.load_ready !== 1'b0) begin bad++; $display("FAIL load_hold_ready got=%0b want=0", a_if.load_ready); end
    total++; if (a_if.busy !== 1'b1) begin bad++; $display("FAIL load_hold_busy got=%0b want=1", a_if.busy); end
    total++; if (a_if.core_reset !== 1'b1) begin bad++; $display("FAIL load_hold1_core_reset got=%0b want=1", a_if.core_reset); end
    tick();
    total++; if (a_if.core_reset !== 1'b1) begin bad++; $display("FAIL load_hold2_core_reset got=%0b want=1", a_if.core_reset); end
    tick();
    total++; if (a_if.core_reset !== 1'b0) begin bad++; $display("FAIL load_run_core_reset got=%0b want=0", a_if.core_reset); end
    repeat (10) tick();
    total++; if (a_if.cycle_cnt !== 16'd10) begin bad++; $display("FAIL run_cnt_pre_done got=%0d want=10", a_if.cycle_cnt); end
    a_if.core_done = 1;
    tick();
    a_if.core_done = 0;
    total++; if (a_if.ack !== 1'b1) begin bad++; $display("FAIL done_ack got=%0b want=1", a_if.ack); end
    total++; if (a_if.err !== 2'd0) begin bad++; $display("FAIL done_err got=%0d want=0", a_if.err); end
    total++; if (a_if.core_reset !== 1'b0) begin bad++; $display("FAIL done_core_reset got=%0b want=0", a_if.core_reset); end
    tick();
    total++; if (a_if.ack !== 1'b1) begin bad++; $display("FAIL done_hold_ack got=%0b want=1", a_if.ack); end
    total++; if (a_if.cycle_cnt !== 16'd10) begin bad++; $display("FAIL done_cnt got=%0d want=10", a_if.cycle_cnt); end
    a_if.req = 0;
    tick();
    total++; if (a_if.ack !== 1'b0) begin bad++; $display("FAIL done_idle_ack got=%0b want=0", a_if.ack); end
    total++; if (a_if.core_reset !== 1'b1) begin bad++; $display("FAIL done_idle_core_reset got=%0b want=1", a_if.core_reset); end
    total++; if (exp_a.size() !== 0) begin bad++; $display("FAIL load_writes_left got=%0d want=0", exp_a.size()); end
  endtask

  task automatic test_timeout();
    int n;
    a_if.req = 1;
    tick(); tick();
    total++; if (a_if.core_reset !== 1'b1) begin bad++; $display("FAIL tmo_hold_core_reset got=%0b want=1", a_if.core_reset); end
    tick();
    total++; if (a_if.core_reset !== 1'b0) begin bad++; $display("FAIL tmo_run_core_reset got=%0b want=0", a_if.core_reset); end
    n = 0;
    while (a_if.ack !== 1'b1 && n < 100) begin tick(); n++; end
    total++; if (n !== 21) begin bad++; $display("FAIL tmo_cycles got=%0d want=21", n); end
    total++; if (a_if.err !== 2'd1) begin bad++; $display("FAIL tmo_err got=%0d want=1", a_if.err); end
    total++; if (a_if.cycle_cnt !== 16'd20) begin bad++; $display("FAIL tmo_cnt got=%0d want=20", a_if.cycle_cnt); end
    total++; if (a_if.core_reset !== 1'b1) begin bad++; $display("FAIL tmo_core_reset got=%0b want=1", a_if.core_reset); end
    a_if.req = 0;
    tick();
    total++; if (a_if.ack !== 1'b0) begin bad++; $display("FAIL tmo_idle_ack got=%0b want=0", a_if.ack); end
    total++; if (a_if.err !== 2'd1) begin bad++; $display("FAIL tmo_err_held got=%0d want=1", a_if.err); end
  endtask

  task automatic test_overflow();
    logic [8:0] w;
    for (int i = 0; i < 9; i++) begin
      w = 9'h100 + 9'(i);
      a_if.load_valid = 1; a_if.load_word = w; a_if.load_last = 0;
      total++;
      if (a_if.load_ready !== (i < 8)) begin bad++; $display("FAIL ovf_ready_%0d got=%0b want=%0b", i, a_if.load_ready, (i < 8)); end
      if (i < 8) exp_a.push_back(i * 512 + int'(w));
      if (i == 8) begin
        total++; if (a_if.err !== 2'd2) begin bad++; $display("FAIL ovf_err got=%0d want=2", a_if.err); end
        total++; if (a_if.ack !== 1'b1) begin bad++; $display("FAIL ovf_ack got=%0b want=1", a_if.ack); end
        total++; if (a_if.core_reset !== 1'b1) begin bad++; $display("FAIL ovf_core_reset got=%0b want=1", a_if.core_reset); end
      end
      tick();
    end
    a_if.load_valid = 0;
    total++; if (a_if.ack !== 1'b0) begin bad++; $display("FAIL ovf_idle_ack got=%0b want=0", a_if.ack); end
    total++; if (a_if.err !== 2'd2) begin bad++; $display("FAIL ovf_err_held got=%0d want=2", a_if.err); end
    total++; if (exp_a.size() !== 0) begin bad++; $display("FAIL ovf_writes_left got=%0d want=0", exp_a.size()); end
  endtask

  task automatic test_reset_mid_run();
    a_if.req = 1;
    tick(); tick(); tick();
    repeat (5) tick();
    total++; if (a_if.cycle_cnt !== 16'd5) begin bad++; $display("FAIL mid_cnt got=%0d want=5", a_if.cycle_cnt); end
    reset = 1;
    tick();
    reset = 0;
    total++; if (a_if.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%0b want=0", a_if.busy); end
    total++; if (a_if.core_reset !== 1'b1) begin bad++; $display("FAIL mid_rst_core_reset got=%0b want=1", a_if.core_reset); end
    total++; if (a_if.cycle_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d want=0", a_if.cycle_cnt); end
    tick();
    total++; if (a_if.busy !== 1'b1) begin bad++; $display("FAIL rerun_hold_busy got=%0b want=1", a_if.busy); end
    tick(); tick();
    total++; if (a_if.core_reset !== 1'b0) begin bad++; $display("FAIL rerun_core_reset got=%0b want=0", a_if.core_reset); end
    a_if.core_done = 1;
    tick();
    a_if.core_done = 0;
    total++; if (a_if.ack !== 1'b1) begin bad++; $display("FAIL rerun_ack got=%0b want=1", a_if.ack); end
    total++; if (a_if.err !== 2'd0) begin bad++; $display("FAIL rerun_err got=%0d want=0", a_if.err); end
    a_if.req = 0;
    tick();
  endtask

  task automatic test_done_tmo_same();
    b_if.req = 1;
    tick(); tick(); tick();
    repeat (8) tick();
    total++; if (b_if.cycle_cnt !== 16'd8) begin bad++; $display("FAIL same_cnt got=%0d want=8", b_if.cycle_cnt); end
    total++; if (b_if.ack !== 1'b0) begin bad++; $display("FAIL same_pre_ack got=%0b want=0", b_if.ack); end
    b_if.core_done = 1;
    tick();
    b_if.core_done = 0;
    total++; if (b_if.ack !== 1'b1) begin bad++; $display("FAIL same_ack got=%0b want=1", b_if.ack); end
    total++; if (b_if.err !== 2'd0) begin bad++; $display("FAIL same_err got=%0d want=0", b_if.err); end
    total++; if (b_if.core_reset !== 1'b0) begin bad++; $display("FAIL same_core_reset got=%0b want=0", b_if.core_reset); end
    b_if.req = 0;
    tick();
    total++; if (b_if.ack !== 1'b0) begin bad++; $display("FAIL same_idle_ack got=%0b want=0", b_if.ack); end
  endtask

  task automatic test_load_req_together();
    a_if.req = 1; a_if.load_valid = 1; a_if.load_word = 9'h0AA; a_if.load_last = 0;
    exp_a.push_back(0 * 512 + 'h0AA);
    tick();
    a_if.load_valid = 0;
    total++; if (a_if.load_ready !== 1'b1) begin bad++; $display("FAIL both_load_ready got=%0b want=1", a_if.load_ready); end
    total++; if (a_if.busy !== 1'b1) begin bad++; $display("FAIL both_busy got=%0b want=1", a_if.busy); end
    tick();
    total++; if (a_if.load_ready !== 1'b1) begin bad++; $display("FAIL both_req_ignored got=%0b want=1", a_if.load_ready); end
    a_if.load_valid = 1; a_if.load_word = 9'h055; a_if.load_last = 1;
    exp_a.push_back(1 * 512 + 'h055);
    tick();
    a_if.load_valid = 0; a_if.load_last = 0;
    total++; if (a_if.load_ready !== 1'b0) begin bad++; $display("FAIL both_hold_ready got=%0b want=0", a_if.load_ready); end
    tick(); tick();
    total++; if (a_if.core_reset !== 1'b0) begin bad++; $display("FAIL both_run_core_reset got=%0b want=0", a_if.core_reset); end
    a_if.core_done = 1;
    tick();
    a_if.core_done = 0;
    total++; if (a_if.ack !== 1'b1) begin bad++; $display("FAIL both_ack got=%0b want=1", a_if.ack); end
    a_if.req = 0;
    tick();
    total++; if (exp_a.size() !== 0) begin bad++; $display("FAIL both_writes_left got=%0d want=0", exp_a.size()); end
    total++; if (exp_b.size() !== 0) begin bad++; $display("FAIL b_writes_left got=%0d want=0", exp_b.size()); end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_timeout();
    test_overflow();
    test_reset_mid_run();
    test_done_tmo_same();
    test_load_req_together();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Sequencer that sits directly upstream of the processor core top level. It streams 9-bit machine words from a host into the writable instruction memory, holds the core in reset while loading, then releases it. It watches the core's done flag, counts execution cycles, and returns a req/ack handshake to the host. A watchdog aborts runs that never finish.

Parameters:
D, 12, instruction-memory address width; equals the core program-counter width
W, 9, machine-code word width
RST_CYC, 2, number of cycles core_reset is held high in HOLD (must be at least 1)
CW, 16, cycle-counter width
MAX_CYC, 16'hFFFF, watchdog limit in RUN cycles; must be less than 2^CW

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; one clock, sampled on posedge clk
req  in  1  host level request: start a run
load_valid  in  1  host word-stream valid
load_word  in  W  machine word to store
load_last  in  1  marks the final word of the program
load_ready  out  1  high in IDLE and LOAD
imem_we  out  1  instruction-memory write strobe
imem_addr  out  D  instruction-memory write address
imem_wdata  out  W  instruction-memory write data
core_reset  out  1  drives the core's reset input
core_done  in  1  the core's done output
busy  out  1  high in LOAD, HOLD and RUN
ack  out  1  high in DONE and ERR; the host drops req to return to IDLE
err  out  2  error code: 0 none, 1 timeout, 2 address overflow; valid while ack is high
cycle_cnt  out  CW  number of RUN cycles counted for the last run

Behaviour:
- States: IDLE, LOAD, HOLD, RUN, DONE, ERR. All outputs are registered except load_ready, busy and ack, which decode the current state.
- Reset values: state=IDLE, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, err=0, cycle_cnt=0.
- Reset asserted in any state, including mid-load or mid-run, returns to IDLE on the next edge. Words already written to instruction memory stay in memory.
- core_reset is 1 in every state except RUN and DONE.
- IDLE:
  - load_valid=1: write load_word, go to LOAD.
  - Otherwise req=1: go to HOLD and re-run the resident program.
  - If both are high, load_valid wins.
- Load transfer: a word is accepted when load_valid and load_ready are both high. On the next cycle imem_we=1, imem_wdata=word and imem_addr=write pointer; the pointer then increments. The write pointer clears to 0 on entry from IDLE. imem_we is a one-cycle pulse per accepted word.
- LOAD:
  - A word accepted with load_last=1 goes to HOLD after its write.
  - A word accepted at pointer 2^D-1 with load_last=0 is written, then the block goes to ERR with err=2. The pointer does not wrap.
  - req is ignored while in LOAD.
- HOLD:
  - Entry clears cycle_cnt and err.
  - Stays for exactly RST_CYC cycles with core_reset=1, then goes to RUN.
- RUN:
  - core_reset=0.
  - cycle_cnt increments every cycle, saturating at MAX_CYC.
  - core_done=1 goes to DONE, and cycle_cnt freezes.
  - Otherwise, when cycle_cnt reaches MAX_CYC, go to ERR with err=1.
  - If core_done and timeout occur in the same cycle, DONE wins.
  - core_done is ignored in every other state.
- DONE: core_reset stays 0 so the core state is observable. Stays until req=0, then goes to IDLE.
- ERR: core_reset=1. Stays until req=0, then goes to IDLE. err holds its value until the next HOLD entry.
- Host handshake: the host must hold req high until ack is seen. If req is already low when DONE or ERR is entered, ack is high for exactly one cycle.
- Latency:
  - From the word with load_last to the first core cycle out of reset: 1 write cycle plus RST_CYC cycles.
  - From req in IDLE to RUN: RST_CYC+1 edges.

Decomposition:
- The shared package core_pkg holds:
  - the state enum run_state_t {IDLE, LOAD, HOLD, RUN, DONE, ERR};
  - the err code constants ERR_NONE, ERR_TMO, ERR_OVF;
  - the widths D and W, shared with the PC and instr_ROM.
- The sub-module run_watchdog contains the cycle counter, the saturate logic and the timeout compare, with ports clr, en, cnt and tmo. The FSM and the load datapath stay in core_run_ctrl.

Test Plan:
- Load 3 words (0x1C8, 0x005, 0x0FF; last on the third) -> imem writes at addresses 0, 1, 2 with matching data; HOLD lasts 2 cycles; core_reset falls on the 3rd cycle after the final write.
- In RUN, assert core_done 10 cycles after core_reset falls, req held high -> DONE, ack=1, err=0, cycle_cnt=10; drop req -> IDLE next cycle.
- MAX_CYC=20, core_done never asserted -> ERR, err=1, cycle_cnt=20, core_reset=1; req low -> IDLE.
- D=3, stream 9 words with no load_last -> 8 writes at addresses 0..7, then ERR with err=2; the 9th word is not accepted (load_ready=0).
- Assert reset mid-RUN at cycle 5 -> IDLE next edge, core_reset=1, cycle_cnt=0. Then req with no load -> HOLD -> RUN re-running the resident program.
- core_done and the timeout in the same cycle (MAX_CYC=8, done at cycle 8) -> DONE with err=0. Separately, load_valid and req together in IDLE -> LOAD.
